// File: rtl/vball_pkg.sv
// Shared definitions for the sound subsystem: ROM/DDRAM widths and the PCM cache state type.
package vball_pkg;

    localparam int unsigned PCM_ADDR_W = 18;
    localparam int unsigned DDR_WORD_W = 64;

    typedef enum logic [1:0] {
        PcmIdle,
        PcmFill,
        PcmPref,
        PcmPwait
    } pcm_cache_state_t;

    // Little-endian byte pick: byte n lives at bits [8n+7:8n].
    function automatic logic [7:0] byte_sel(input logic [DDR_WORD_W-1:0] word,
                                            input logic [2:0] sel);
        return word[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/pcm_cache_mem.sv
// Direct-mapped line storage for the PCM ROM cache: one write port, two async read ports.
module pcm_cache_mem
    import vball_pkg::*;
#(
    parameter int unsigned IDX_W = 2,
    parameter int unsigned TAG_W = 13
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      widx_i,
    input  logic [TAG_W-1:0]      wtag_i,
    input  logic [DDR_WORD_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]      ra_idx_i,
    output logic [TAG_W-1:0]      ra_tag_o,
    output logic                  ra_valid_o,
    output logic [DDR_WORD_W-1:0] ra_data_o,
    input  logic [IDX_W-1:0]      rb_idx_i,
    output logic [TAG_W-1:0]      rb_tag_o,
    output logic                  rb_valid_o
);

    localparam int unsigned Lines = 1 << IDX_W;

    logic [Lines-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_q  [Lines];
    logic [DDR_WORD_W-1:0] data_q [Lines];

    // Valid bits: cleared on reset or flush; clear wins over a same-cycle write.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[widx_i] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign ra_tag_o   = tag_q[ra_idx_i];
    assign ra_valid_o = valid_q[ra_idx_i];
    assign ra_data_o  = data_q[ra_idx_i];
    assign rb_tag_o   = tag_q[rb_idx_i];
    assign rb_valid_o = valid_q[rb_idx_i];

endmodule

// File: rtl/pcm_rom_cache.sv
// Byte-wide PCM ROM read port served from a small direct-mapped cache of 64-bit DDRAM lines.
module pcm_rom_cache
    import vball_pkg::*;
#(
    parameter int unsigned ADDR_W   = PCM_ADDR_W,
    parameter int unsigned IDX_W    = 2,
    parameter int unsigned PREFETCH = 1
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  rd_req,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [7:0]            rd_data,
    output logic                  rd_rdy,
    output logic                  rd_busy,
    output logic [ADDR_W-1:0]     ddr_addr,
    output logic                  ddr_req,
    input  logic [DDR_WORD_W-1:0] ddr_data,
    input  logic                  ddr_ready
);

    localparam int unsigned LineW = ADDR_W - 3;
    localparam int unsigned TagW  = LineW - IDX_W;

    pcm_cache_state_t  state_q;
    logic              rd_rdy_q;
    logic              rd_busy_q;
    logic [7:0]        rd_data_q;
    logic              ddr_req_q;
    logic [ADDR_W-1:0] ddr_addr_q;
    logic [ADDR_W-1:0] dem_addr_q;

    logic [LineW-1:0]      req_line, ddr_line, dem_line, next_line;
    logic [IDX_W-1:0]      req_idx, ddr_idx, next_idx;
    logic [TagW-1:0]       req_tag, ddr_tag, next_tag;
    logic [TagW-1:0]       ra_tag, rb_tag;
    logic                  ra_valid, rb_valid;
    logic [DDR_WORD_W-1:0] ra_data;
    logic                  ddr_fire, accept, same_idx, in_pf_line, hit, pf_ok;
    logic [7:0]            hit_byte;

    // Address split for the incoming request, the outstanding DDR line and the demand line.
    always_comb begin
        req_line  = rd_addr[ADDR_W-1:3];
        req_idx   = req_line[IDX_W-1:0];
        req_tag   = req_line[LineW-1:IDX_W];
        ddr_line  = ddr_addr_q[ADDR_W-1:3];
        ddr_idx   = ddr_line[IDX_W-1:0];
        ddr_tag   = ddr_line[LineW-1:IDX_W];
        dem_line  = dem_addr_q[ADDR_W-1:3];
        next_line = dem_line + LineW'(1);
        next_idx  = next_line[IDX_W-1:0];
        next_tag  = next_line[LineW-1:IDX_W];
    end

    // Lookup. A request aimed at the slot being refilled only hits when the refill lands this
    // very cycle (bypass from ddr_data); otherwise the slot's old contents are about to vanish.
    always_comb begin
        ddr_fire   = ddr_req_q && ddr_ready;
        accept     = rd_req && !rd_busy_q;
        same_idx   = ddr_req_q && (req_idx == ddr_idx);
        in_pf_line = ddr_req_q && (req_line == ddr_line);
        if (same_idx) begin
            hit      = !flush && ddr_fire && in_pf_line;
            hit_byte = byte_sel(ddr_data, rd_addr[2:0]);
        end else begin
            hit      = !flush && ra_valid && (ra_tag == req_tag);
            hit_byte = byte_sel(ra_data, rd_addr[2:0]);
        end
        // No prefetch past the top of ROM space, of a line already present, or while flushing.
        pf_ok = (PREFETCH != 0) && !flush && (dem_line != '1) && !(rb_valid && rb_tag == next_tag);
    end

    pcm_cache_mem #(
        .IDX_W (IDX_W),
        .TAG_W (TagW)
    ) u_mem (
        .clk_i      (clk_sys),
        .rst_ni     (reset_n),
        .clr_i      (flush),
        .we_i       (ddr_fire),
        .widx_i     (ddr_idx),
        .wtag_i     (ddr_tag),
        .wdata_i    (ddr_data),
        .ra_idx_i   (req_idx),
        .ra_tag_o   (ra_tag),
        .ra_valid_o (ra_valid),
        .ra_data_o  (ra_data),
        .rb_idx_i   (next_idx),
        .rb_tag_o   (rb_tag),
        .rb_valid_o (rb_valid)
    );

    // Cache controller: request acceptance, demand fill, prefetch and registered outputs.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= PcmIdle;
            rd_rdy_q   <= 1'b0;
            rd_busy_q  <= 1'b0;
            rd_data_q  <= '0;
            ddr_req_q  <= 1'b0;
            ddr_addr_q <= '0;
            dem_addr_q <= '0;
        end else begin
            rd_rdy_q  <= 1'b0;
            rd_busy_q <= 1'b0;
            unique case (state_q)
                PcmIdle: begin
                    if (accept) begin
                        rd_busy_q <= 1'b1;
                        if (hit) begin
                            rd_rdy_q  <= 1'b1;
                            rd_data_q <= hit_byte;
                        end else begin
                            ddr_req_q  <= 1'b1;
                            ddr_addr_q <= {req_line, 3'b000};
                            dem_addr_q <= rd_addr;
                            state_q    <= PcmFill;
                        end
                    end
                end
                PcmFill: begin
                    rd_busy_q <= 1'b1;
                    if (ddr_fire) begin
                        rd_rdy_q  <= 1'b1;
                        rd_data_q <= byte_sel(ddr_data, dem_addr_q[2:0]);
                        if (pf_ok) begin
                            ddr_addr_q <= {next_line, 3'b000};
                            state_q    <= PcmPref;
                        end else begin
                            ddr_req_q <= 1'b0;
                            state_q   <= PcmIdle;
                        end
                    end
                end
                PcmPref: begin
                    if (accept && hit) begin
                        rd_rdy_q  <= 1'b1;
                        rd_busy_q <= 1'b1;
                        rd_data_q <= hit_byte;
                        if (ddr_fire) begin
                            ddr_req_q <= 1'b0;
                            state_q   <= PcmIdle;
                        end
                    end else if (accept) begin
                        rd_busy_q  <= 1'b1;
                        dem_addr_q <= rd_addr;
                        if (ddr_fire) begin
                            // Prefetch just landed; go straight to the demand fill.
                            ddr_addr_q <= {req_line, 3'b000};
                            state_q    <= PcmFill;
                        end else begin
                            state_q <= PcmPwait;
                        end
                    end else if (ddr_fire) begin
                        ddr_req_q <= 1'b0;
                        state_q   <= PcmIdle;
                    end
                end
                PcmPwait: begin
                    rd_busy_q <= 1'b1;
                    if (ddr_fire) begin
                        if (dem_line == ddr_line) begin
                            rd_rdy_q  <= 1'b1;
                            rd_data_q <= byte_sel(ddr_data, dem_addr_q[2:0]);
                            ddr_req_q <= 1'b0;
                            state_q   <= PcmIdle;
                        end else begin
                            ddr_addr_q <= {dem_line, 3'b000};
                            state_q    <= PcmFill;
                        end
                    end
                end
                default: begin
                    ddr_req_q <= 1'b0;
                    state_q   <= PcmIdle;
                end
            endcase
        end
    end

    assign rd_rdy   = rd_rdy_q;
    assign rd_busy  = rd_busy_q;
    assign rd_data  = rd_data_q;
    assign ddr_req  = ddr_req_q;
    assign ddr_addr = ddr_addr_q;

endmodule

// File: tb/tb_pcm_rom_cache.sv
// Directed bench for pcm_rom_cache with a scoreboard of expected read bytes.
module tb_pcm_rom_cache;
    import vball_pkg::*;

    localparam int unsigned AW = 18;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          rd_rdy;
    logic          rd_busy;
    logic [AW-1:0] ddr_addr;
    logic          ddr_req;
    logic [63:0]   ddr_data;
    logic          ddr_ready;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    pcm_rom_cache #(
        .ADDR_W   (AW),
        .IDX_W    (2),
        .PREFETCH (1)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .flush     (flush),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_rdy    (rd_rdy),
        .rd_busy   (rd_busy),
        .ddr_addr  (ddr_addr),
        .ddr_req   (ddr_req),
        .ddr_data  (ddr_data),
        .ddr_ready (ddr_ready)
    );

    always #5 clk_sys = ~clk_sys;

    // ROM contents model: one 64-bit word per line.
    function automatic logic [63:0] line_word(input logic [AW-1:0] a);
        logic [15:0] k;
        if ({a[AW-1:3], 3'b000} == 18'h00010) return 64'h8877665544332211;
        k = a[17:2];
        return {k ^ 16'h5A3C, k ^ 16'hC3A5, ~k, k};
    endfunction

    function automatic logic [7:0] exp_byte(input logic [AW-1:0] a);
        logic [63:0] w;
        w = line_word(a);
        return w[{a[2:0], 3'b000} +: 8];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Waits out rd_busy, then pulses a read and records its expected byte.
    task automatic issue(input logic [AW-1:0] a);
        int n = 0;
        while (rd_busy === 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("busy_timeout", 1, 0);
        rd_req  = 1'b1;
        rd_addr = a;
        exp_q.push_back(exp_byte(a));
        step();
        rd_req = 1'b0;
    endtask

    // Read pulse with no expectation; used where it must be dropped.
    task automatic poke(input logic [AW-1:0] a);
        rd_req  = 1'b1;
        rd_addr = a;
        step();
        rd_req = 1'b0;
    endtask

    task automatic wait_req(input logic [AW-1:0] a);
        int n = 0;
        while (ddr_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("ddr_req_raised", ddr_req, 1);
        check("ddr_addr", ddr_addr, a);
    endtask

    task automatic respond(input logic [AW-1:0] a);
        ddr_ready = 1'b1;
        ddr_data  = line_word(a);
        step();
        ddr_ready = 1'b0;
        ddr_data  = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        step();
        check("reads_outstanding", exp_q.size(), 0);
    endtask

    // Scoreboard: every rd_rdy pulse must match the oldest outstanding expectation.
    always @(negedge clk_sys) begin
        if (reset_n === 1'b1 && rd_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rd_rdy", 1, 0);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        ddr_ready = 1'b0;
        ddr_data  = '0;
        repeat (3) step();
        check("reset_rd_rdy", rd_rdy, 0);
        check("reset_rd_busy", rd_busy, 0);
        check("reset_ddr_req", ddr_req, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_ddr_addr", ddr_addr, 0);
        reset_n = 1'b1;
        step();

        // Demand miss, fill, then prefetch of the next line.
        issue(18'h00010);
        wait_req(18'h00010);
        respond(18'h00010);
        check("fill_rdy", rd_rdy, 1);
        check("fill_byte", rd_data, 8'h11);
        wait_req(18'h00018);
        // Read inside the prefetch line is served on its ready.
        issue(18'h0001A);
        check("pwait_keeps_prefetch", ddr_addr, 18'h00018);
        respond(18'h00018);
        drain();
        check("idle_no_ddr_req", ddr_req, 0);

        // Hit: latency one, no DDR traffic.
        issue(18'h00017);
        check("hit_latency", rd_rdy, 1);
        check("hit_byte", rd_data, 8'h88);
        check("hit_no_ddr", ddr_req, 0);
        drain();

        // Unrelated miss behind a prefetch: prefetch first, then the demand fill.
        issue(18'h00040);
        wait_req(18'h00040);
        respond(18'h00040);
        wait_req(18'h00048);
        issue(18'h20000);
        check("miss_waits_prefetch", ddr_addr, 18'h00048);
        respond(18'h00048);
        wait_req(18'h20000);
        check("no_early_rdy", rd_rdy, 0);
        respond(18'h20000);
        wait_req(18'h20008);
        // Hit on another line while a prefetch is outstanding.
        issue(18'h00017);
        check("pref_hit_latency", rd_rdy, 1);
        check("pref_still_req", ddr_req, 1);
        check("pref_still_addr", ddr_addr, 18'h20008);
        respond(18'h20008);
        drain();
        check("after_pref_idle", ddr_req, 0);

        // Flush invalidates; a fill under flush returns data but is not kept.
        flush = 1'b1;
        step();
        flush = 1'b0;
        issue(18'h00010);
        wait_req(18'h00010);
        flush = 1'b1;
        respond(18'h00010);
        check("flush_no_prefetch", ddr_req, 0);
        drain();
        flush = 1'b0;
        step();
        issue(18'h00010);
        wait_req(18'h00010);
        respond(18'h00010);
        wait_req(18'h00018);
        respond(18'h00018);
        drain();

        // Reset in the middle of a fill, then a stray ready.
        issue(18'h00100);
        wait_req(18'h00100);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        exp_q.delete();
        ddr_ready = 1'b1;
        ddr_data  = line_word(18'h00100);
        step();
        ddr_ready = 1'b0;
        repeat (3) step();
        check("stray_ready_no_req", ddr_req, 0);
        check("stray_ready_not_busy", rd_busy, 0);
        issue(18'h00017);
        wait_req(18'h00010);
        respond(18'h00010);
        wait_req(18'h00018);
        respond(18'h00018);
        drain();

        // Last line of ROM space: no wrapping prefetch; read during busy is dropped.
        issue(18'h3FFF8);
        wait_req(18'h3FFF8);
        poke(18'h00017);
        respond(18'h3FFF8);
        check("last_line_no_prefetch", ddr_req, 0);
        drain();
        check("last_line_idle", rd_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
